// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter fed by a small circular FIFO. Core-side logic pushes
//   words with a valid/ready handshake. Queued words are serialised
//   back-to-back: start bit, DATA_BITS data bits LSB first, an optional
//   parity bit, then STOP_BITS stop bits.
//
// Ports
//   i_Clock       single clock, all logic on posedge
//   i_Rst_L       asynchronous active-low reset
//   i_Tx_DV       write strobe, accepted when i_Tx_DV && o_Tx_Ready
//   i_Tx_Byte     data word to queue
//   o_Tx_Ready    FIFO not full (registered occupancy below FIFO_DEPTH)
//   o_Tx_Serial   registered serial line, idles high
//   o_Tx_Active   high while the line carries start/data/parity/stop
//   o_Tx_Done     one-cycle pulse on the first cycle after a frame's last stop bit
//   o_Tx_Idle     FSM in IDLE and FIFO empty
//   o_Tx_Overflow one-cycle pulse after a write was rejected because the FIFO was full
//   o_Fifo_Count  current FIFO occupancy
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               i_Clock,
    input  logic                               i_Rst_L,
    input  logic                               i_Tx_DV,
    input  logic [DATA_BITS-1:0]               i_Tx_Byte,
    output logic                               o_Tx_Ready,
    output logic                               o_Tx_Serial,
    output logic                               o_Tx_Active,
    output logic                               o_Tx_Done,
    output logic                               o_Tx_Idle,
    output logic                               o_Tx_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_Fifo_Count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit that goes out after the data bits of a given word.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1)      return ~(^d);
        else if (PARITY == 2) return ^d;
        else                  return 1'b0;
    endfunction

    // ---------------------------------------------------------------- FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]     count_q, count_d;
    logic                 overflow_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    // Ready looks only at the registered count, so a write into a full FIFO
    // is dropped even when a pop frees a slot in the same cycle.
    assign o_Tx_Ready = (count_q < OCC_FULL);
    assign push       = i_Tx_DV && o_Tx_Ready;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + OCC_W'(1);
        else if (!push && pop) count_d = count_q - OCC_W'(1);
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            overflow_q <= i_Tx_DV && !o_Tx_Ready;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) mem_q[wr_ptr_q] <= i_Tx_Byte;
    end

    // ----------------------------------------------------------------- FSM
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 bit_tick, frame_end;

    assign bit_tick = (clk_cnt_q == BIT_LAST);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_tick ? '0 : clk_cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pop       = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = parity_bit(head);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (bit_idx_q == STOP_LAST) begin
                        frame_end = 1'b1;
                        bit_idx_d = '0;
                        // Chain straight into the next start bit when data is queued.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = parity_bit(head);
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------- line outputs
    logic serial_d, active_d;
    logic serial_q, active_q, end_q, done_q;

    always_comb begin
        serial_d = 1'b1;
        active_d = 1'b0;
        case (state_q)
            S_START:  begin serial_d = 1'b0;       active_d = 1'b1; end
            S_DATA:   begin serial_d = shift_q[0]; active_d = 1'b1; end
            S_PARITY: begin serial_d = par_q;      active_d = 1'b1; end
            S_STOP:   begin serial_d = 1'b1;       active_d = 1'b1; end
            default:  begin serial_d = 1'b1;       active_d = 1'b0; end
        endcase
    end

    // The line lags the FSM by one register, so the end-of-frame flag is
    // delayed twice to land on the first cycle after the last stop bit.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            serial_q <= 1'b1;
            active_q <= 1'b0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            serial_q <= serial_d;
            active_q <= active_d;
            end_q    <= frame_end;
            done_q   <= end_q;
        end
    end

    assign o_Tx_Serial   = serial_q;
    assign o_Tx_Active   = active_q;
    assign o_Tx_Done     = done_q;
    assign o_Tx_Idle     = (state_q == S_IDLE) && (count_q == '0);
    assign o_Tx_Overflow = overflow_q;
    assign o_Fifo_Count  = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] dv;
    logic [7:0] b0, b1, b2;
    logic [4:0] b3;
    logic [3:0] rdy, ser, act, done, idle, ovf;
    logic [2:0] cnt [4];

    // 0: 8N1   1: 8O1   2: 8E2   3: 5N1  (all 4 clocks per bit, depth 4)
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(b0),
        .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0]),
        .o_Tx_Idle(idle[0]), .o_Tx_Overflow(ovf[0]), .o_Fifo_Count(cnt[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(b1),
        .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1]),
        .o_Tx_Idle(idle[1]), .o_Tx_Overflow(ovf[1]), .o_Fifo_Count(cnt[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(b2),
        .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2]),
        .o_Tx_Idle(idle[2]), .o_Tx_Overflow(ovf[2]), .o_Fifo_Count(cnt[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(b3),
        .o_Tx_Ready(rdy[3]), .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(done[3]),
        .o_Tx_Idle(idle[3]), .o_Tx_Overflow(ovf[3]), .o_Fifo_Count(cnt[3]));

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    // Per-cycle history of each DUT, sampled 1 time unit after the posedge.
    logic       hser  [4][2048];
    logic       hact  [4][2048];
    logic       hdone [4][2048];
    logic [2:0] hcnt  [4][2048];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 2048) begin
            for (int d = 0; d < 4; d++) begin
                hser[d][cyc]  = ser[d];
                hact[d][cyc]  = act[d];
                hdone[d][cyc] = done[d];
                hcnt[d][cyc]  = cnt[d];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int act_sum(input int d, input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) if (hact[d][i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int done_sum(input int d, input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) if (hdone[d][i] === 1'b1) s++;
        return s;
    endfunction

    function automatic int low_sum(input int d, input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) if (hser[d][i] !== 1'b1) s++;
        return s;
    endfunction

    // Samples n consecutive bit periods (second cycle of each) from line cycle s.
    function automatic logic [15:0] line_bits(input int d, input int s, input int n);
        logic [15:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = hser[d][s + 1 + 4 * k];
        return v;
    endfunction

    // Data bits of a frame whose start bit is on the line at cycle s.
    function automatic logic [8:0] frame_data(input int d, input int s, input int nbits);
        logic [8:0] v = '0;
        for (int i = 0; i < nbits; i++) v[i] = hser[d][s + 5 + 4 * i];
        return v;
    endfunction

    task automatic drive(input int d, input logic en, input logic [7:0] data);
        dv[d] = en;
        case (d)
            0: b0 = data;
            1: b1 = data;
            2: b2 = data;
            default: b3 = data[4:0];
        endcase
    endtask

    // Single write, then 60 cycles of observation; returns the write cycle.
    task automatic run_frame(input int d, input logic [7:0] data, output int w);
        drive(d, 1'b1, data);
        tick();
        w = cyc;
        drive(d, 1'b0, 8'h00);
        repeat (60) tick();
    endtask

    logic [7:0] burst [6];
    int w, b, p, r, rs;

    initial begin
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
        burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
        rst_n = 1'b0;
        dv = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_serial",   ser[0],  1);
        check("rst_active",   act[0],  0);
        check("rst_done",     done[0], 0);
        check("rst_idle",     idle[0], 1);
        check("rst_ready",    rdy[0],  1);
        check("rst_overflow", ovf[0],  0);
        check("rst_count",    cnt[0],  0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 0xA5, 8N1
        run_frame(0, 8'hA5, w);
        check("a5_count_w1",   hcnt[0][w],   1);
        check("a5_count_w2",   hcnt[0][w+1], 0);
        check("a5_line_w1",    hser[0][w+1], 1);
        check("a5_start_w2",   hser[0][w+2], 0);
        check("a5_act_w1",     hact[0][w+1], 0);
        check("a5_line",       line_bits(0, w + 2, 10), 16'b1101001010);
        check("a5_frame_len",  act_sum(0, w + 1, w + 60), 40);
        check("a5_done_count", done_sum(0, w + 1, w + 60), 1);
        check("a5_done_at",    hdone[0][w+42], 1);
        check("a5_idle_end",   idle[0], 1);

        // 0x07 odd parity
        run_frame(1, 8'h07, w);
        check("odd_line",      line_bits(1, w + 2, 11), 16'b10000001110);
        check("odd_parity",    hser[1][w+39], 0);
        check("odd_frame_len", act_sum(1, w + 1, w + 60), 44);

        // 0x07 even parity, two stop bits
        run_frame(2, 8'h07, w);
        check("even_parity",    hser[2][w+39], 1);
        check("even_stop1",     hser[2][w+43], 1);
        check("even_stop2",     hser[2][w+47], 1);
        check("even_frame_len", act_sum(2, w + 1, w + 60), 48);
        check("even_act_last",  hact[2][w+49], 1);
        check("even_act_after", hact[2][w+50], 0);
        check("even_done_at",   hdone[2][w+50], 1);

        // 0x1F, 5 data bits
        run_frame(3, 8'h1F, w);
        check("five_line",      line_bits(3, w + 2, 7), 16'b1111110);
        check("five_frame_len", act_sum(3, w + 1, w + 60), 28);
        check("five_done",      done_sum(3, w + 1, w + 60), 1);

        // Burst of 6 writes into a depth-4 FIFO
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b1, burst[k]);
            tick();
            if (k == 0) b = cyc;
            if (k == 3) check("burst_ready_k3", rdy[0], 1);
            if (k == 4) check("burst_ready_full", rdy[0], 0);
            if (k == 5) check("burst_overflow", ovf[0], 1);
        end
        drive(0, 1'b0, 8'h00);
        tick();
        check("burst_overflow_end", ovf[0], 0);
        check("burst_count_hold",   cnt[0], 4);
        repeat (210) tick();
        check("burst_count_seq",
              {hcnt[0][b], hcnt[0][b+1], hcnt[0][b+2], hcnt[0][b+3], hcnt[0][b+4]},
              {3'd1, 3'd1, 3'd2, 3'd3, 3'd4});
        check("burst_act_before", hact[0][b+1], 0);
        check("burst_act_span",   act_sum(0, b + 2, b + 201), 200);
        check("burst_act_after",  hact[0][b+202], 0);
        check("burst_done_count", done_sum(0, b, b + 210), 5);
        check("burst_done_b2b",   hdone[0][b+42], 1);
        check("burst_start_b2b",  hser[0][b+42], 0);
        for (int k = 0; k < 5; k++)
            check($sformatf("burst_word%0d", k), frame_data(0, b + 2 + 40 * k, 8), burst[k]);

        // Push and pop on the final stop cycle with two words queued
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b1, (k == 0) ? 8'h3C : (k == 1) ? 8'hC3 : 8'h5A);
            tick();
            if (k == 0) p = cyc;
        end
        drive(0, 1'b0, 8'h00);
        check("pp_count_pre", hcnt[0][p+2], 2);
        while (cyc < p + 40) tick();
        check("pp_count_last_stop", cnt[0], 2);
        drive(0, 1'b1, 8'h99);
        tick();
        drive(0, 1'b0, 8'h00);
        check("pp_count_same", cnt[0], 2);
        check("pp_ready",      rdy[0], 1);
        tick();
        check("pp_no_overflow", ovf[0], 0);
        check("pp_count_after", cnt[0], 2);
        repeat (170) tick();
        check("pp_done_count", done_sum(0, p, p + 210), 4);
        check("pp_last_word",  frame_data(0, p + 122, 8), 8'h99);
        check("pp_drain_idle", idle[0], 1);
        check("pp_drain_count", cnt[0], 0);

        // Reset in the middle of the data bits
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 8'h00);
            tick();
            if (k == 0) r = cyc;
        end
        drive(0, 1'b0, 8'h00);
        while (cyc < r + 15) tick();
        check("mid_line_low", ser[0], 0);
        check("mid_count",    cnt[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_serial", ser[0], 1);
        check("rst_mid_count",  cnt[0], 0);
        check("rst_mid_active", act[0], 0);
        repeat (2) tick();
        rst_n = 1'b1;
        rs = cyc;
        repeat (60) tick();
        check("post_rst_active", act_sum(0, rs + 1, rs + 60), 0);
        check("post_rst_done",   done_sum(0, rs + 1, rs + 60), 0);
        check("post_rst_line",   low_sum(0, rs + 1, rs + 60), 0);
        check("post_rst_idle",   idle[0], 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
